// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and helpers for the EX-stage hazard controller.
// Destination decode lives here so the controller and any future consumers agree on it.
package pipe_ctrl_pkg;

    localparam logic [1:0] REGDST_RT   = 2'b00;
    localparam logic [1:0] REGDST_RD   = 2'b01;
    localparam logic [1:0] REGDST_RA   = 2'b10;
    localparam logic [1:0] REGDST_NONE = 2'b11;

    localparam logic [1:0] MEM2REG_LOAD = 2'b01;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_BR_FLUSH = 2'b10
    } ctrl_state_t;

    typedef struct packed {
        logic [4:0] dst;
        logic       we;
        logic       load;
    } exmem_shadow_t;

    function automatic logic [4:0] decode_dst(input logic [1:0] sel,
                                              input logic [4:0] rt,
                                              input logic [4:0] rd);
        logic [4:0] dst;
        dst = 5'd0;
        case (sel)
            REGDST_RT: dst = rt;
            REGDST_RD: dst = rd;
            REGDST_RA: dst = 5'd31;
            default:   dst = 5'd0;
        endcase
        return dst;
    endfunction

endpackage

// File: rtl/ex_hazard_ctrl_fwd_select.sv
// Forwarding select for one ALU operand: compares the source register against the
// EX/MEM and MEM/WB shadows, EX/MEM winning because it holds the younger result.
module fwd_select
    import pipe_ctrl_pkg::*;
(
    input  logic       exmem_we,
    input  logic       exmem_load,
    input  logic [4:0] exmem_dst,
    input  logic       memwb_we,
    input  logic [4:0] memwb_dst,
    input  logic [4:0] src_addr,
    output logic [1:0] fwd_sel
);

    // A load in EX/MEM has no data yet, so it can only be forwarded once it reaches MEM/WB.
    always_comb begin
        fwd_sel = FWD_REG;
        if (exmem_we && !exmem_load && (exmem_dst == src_addr)) begin
            fwd_sel = FWD_EXMEM;
        end else if (memwb_we && (memwb_dst == src_addr)) begin
            fwd_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: forwarding selects, load-use stall and taken-branch flush,
// with its own shadow of the EX/MEM and MEM/WB destinations and saturating event counters.
module ex_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             IdEx_RegWriteEN,
    input  logic [1:0]       IdEx_Mem2RegSEL,
    input  logic [1:0]       IdEx_RegDstSEL,
    input  logic [4:0]       IdEx_RSAddr,
    input  logic [4:0]       IdEx_RTAddr,
    input  logic [4:0]       IdEx_RDAddr,
    input  logic             IdEx_Beq,
    input  logic             IdEx_Bne,
    input  logic             ALUZero,
    input  logic [4:0]       IfId_RSAddr,
    input  logic [4:0]       IfId_RTAddr,
    output logic [1:0]       FwdA_SEL,
    output logic [1:0]       FwdB_SEL,
    output logic             Stall,
    output logic             IdExFlush,
    output logic             IfIdFlush,
    output logic             BranchTaken,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);

    ctrl_state_t       state, state_nxt;
    logic [FCNT_W-1:0] fcnt, fcnt_nxt;

    exmem_shadow_t     ex_mem;
    logic [4:0]        memwb_dst;
    logic              memwb_we;
    logic              flush_d;

    logic [4:0]        idex_dst;
    logic              idex_we_eff;
    logic              idex_load;
    logic              branch_taken;
    logic              load_use;

    logic              stall_c, idex_flush_c, ifid_flush_c, taken_c;
    logic              stall_inc, flush_inc;
    logic [1:0]        fwd_a, fwd_b;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    assign idex_dst     = decode_dst(IdEx_RegDstSEL, IdEx_RTAddr, IdEx_RDAddr);
    assign idex_we_eff  = IdEx_RegWriteEN && (IdEx_RegDstSEL != REGDST_NONE) && (idex_dst != 5'd0);
    assign idex_load    = (IdEx_Mem2RegSEL == MEM2REG_LOAD);
    assign branch_taken = (IdEx_Beq && ALUZero) || (IdEx_Bne && !ALUZero);
    assign load_use     = idex_load && idex_we_eff &&
                          ((idex_dst == IfId_RSAddr) || (idex_dst == IfId_RTAddr));

    fwd_select u_fwd_a (
        .exmem_we   (ex_mem.we),
        .exmem_load (ex_mem.load),
        .exmem_dst  (ex_mem.dst),
        .memwb_we   (memwb_we),
        .memwb_dst  (memwb_dst),
        .src_addr   (IdEx_RSAddr),
        .fwd_sel    (fwd_a)
    );

    fwd_select u_fwd_b (
        .exmem_we   (ex_mem.we),
        .exmem_load (ex_mem.load),
        .exmem_dst  (ex_mem.dst),
        .memwb_we   (memwb_we),
        .memwb_dst  (memwb_dst),
        .src_addr   (IdEx_RTAddr),
        .fwd_sel    (fwd_b)
    );

    // Branch wins over load-use: the dependent instruction in ID is on the wrong path anyway.
    always_comb begin
        state_nxt    = state;
        fcnt_nxt     = fcnt;
        stall_c      = 1'b0;
        idex_flush_c = 1'b0;
        ifid_flush_c = 1'b0;
        taken_c      = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (branch_taken) begin
                    taken_c      = 1'b1;
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                    flush_inc    = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt = ST_BR_FLUSH;
                        fcnt_nxt  = FCNT_W'(FLUSH_CYCLES - 1);
                    end
                end else if (load_use) begin
                    stall_c      = 1'b1;
                    idex_flush_c = 1'b1;
                    stall_inc    = 1'b1;
                    state_nxt    = ST_LU_STALL;
                end
            end
            ST_LU_STALL: begin
                state_nxt = ST_RUN;
            end
            ST_BR_FLUSH: begin
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
                if (fcnt <= FCNT_W'(1)) begin
                    state_nxt = ST_RUN;
                    fcnt_nxt  = '0;
                end else begin
                    fcnt_nxt  = fcnt - FCNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_RUN;
                fcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= ST_RUN;
            fcnt  <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // The cycle after a flush the ID/EX register holds a bubble, so its write is discarded here.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            ex_mem    <= '0;
            memwb_dst <= 5'd0;
            memwb_we  <= 1'b0;
            flush_d   <= 1'b0;
        end else begin
            ex_mem.dst  <= idex_dst;
            ex_mem.we   <= idex_we_eff && !flush_d;
            ex_mem.load <= idex_load;
            memwb_dst   <= ex_mem.dst;
            memwb_we    <= ex_mem.we;
            flush_d     <= idex_flush_c;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && !(&flush_cnt)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign FwdA_SEL    = RESET ? FWD_REG : fwd_a;
    assign FwdB_SEL    = RESET ? FWD_REG : fwd_b;
    assign Stall       = stall_c      && !RESET;
    assign IdExFlush   = idex_flush_c && !RESET;
    assign IfIdFlush   = ifid_flush_c && !RESET;
    assign BranchTaken = taken_c      && !RESET;
    assign StallCount  = stall_cnt;
    assign FlushCount  = flush_cnt;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed hazard scenarios then random traffic, all checked
// against a pipeline-history model; counters are narrowed so saturation is reachable.
module tb_ex_hazard_ctrl;

    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             regwrite = 1'b0;
    logic [1:0]       mem2reg = 2'b00;
    logic [1:0]       regdst = 2'b11;
    logic [4:0]       rs = 5'd0, rt = 5'd0, rd = 5'd0;
    logic             beq = 1'b0, bne = 1'b0, zero = 1'b0;
    logic [4:0]       ifid_rs = 5'd0, ifid_rt = 5'd0;
    logic [1:0]       fwd_a, fwd_b;
    logic             stall, idex_flush, ifid_flush, br_taken;
    logic [CNT_W-1:0] stall_count, flush_count;

    int checks = 0;
    int errors = 0;

    // Model: the last two destinations that really advanced, plus pending masked cycles.
    int m_exmem_dst, m_memwb_dst;
    bit m_exmem_we, m_exmem_ld, m_memwb_we, m_prev_flush;
    bit m_lu_hold;
    int m_flush_left;
    int m_stall_cnt, m_flush_cnt;
    int e_fwda, e_fwdb;
    bit e_stall, e_idexflush, e_ifidflush, e_taken;

    ex_hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .CLOCK           (clock),
        .RESET           (reset),
        .IdEx_RegWriteEN (regwrite),
        .IdEx_Mem2RegSEL (mem2reg),
        .IdEx_RegDstSEL  (regdst),
        .IdEx_RSAddr     (rs),
        .IdEx_RTAddr     (rt),
        .IdEx_RDAddr     (rd),
        .IdEx_Beq        (beq),
        .IdEx_Bne        (bne),
        .ALUZero         (zero),
        .IfId_RSAddr     (ifid_rs),
        .IfId_RTAddr     (ifid_rt),
        .FwdA_SEL        (fwd_a),
        .FwdB_SEL        (fwd_b),
        .Stall           (stall),
        .IdExFlush       (idex_flush),
        .IfIdFlush       (ifid_flush),
        .BranchTaken     (br_taken),
        .StallCount      (stall_count),
        .FlushCount      (flush_count)
    );

    always #5 clock = ~clock;

    function automatic int dest_of(input int sel, input int t, input int d);
        case (sel)
            0: return t;
            1: return d;
            2: return 31;
            default: return 0;
        endcase
    endfunction

    function automatic int fwd_of(input int src);
        if (m_exmem_we && !m_exmem_ld && m_exmem_dst == src) return 1;
        if (m_memwb_we && m_memwb_dst == src) return 2;
        return 0;
    endfunction

    task automatic modelReset();
        m_exmem_dst = 0; m_memwb_dst = 0;
        m_exmem_we = 0; m_exmem_ld = 0; m_memwb_we = 0; m_prev_flush = 0;
        m_lu_hold = 0; m_flush_left = 0;
        m_stall_cnt = 0; m_flush_cnt = 0;
    endtask

    task automatic computeExpected();
        int dst;
        bit we, ld, br, lu;
        dst = dest_of(int'(regdst), int'(rt), int'(rd));
        we  = regwrite && (dst != 0);
        ld  = (mem2reg == 2'b01);
        e_fwda = 0; e_fwdb = 0;
        e_stall = 0; e_idexflush = 0; e_ifidflush = 0; e_taken = 0;
        if (reset) return;
        e_fwda = fwd_of(int'(rs));
        e_fwdb = fwd_of(int'(rt));
        if (m_lu_hold) begin
        end else if (m_flush_left > 0) begin
            e_idexflush = 1; e_ifidflush = 1;
        end else begin
            br = (beq && zero) || (bne && !zero);
            lu = ld && we && (dst == int'(ifid_rs) || dst == int'(ifid_rt));
            if (br) begin
                e_taken = 1; e_idexflush = 1; e_ifidflush = 1;
            end else if (lu) begin
                e_stall = 1; e_idexflush = 1;
            end
        end
    endtask

    task automatic advanceModel();
        int dst;
        if (reset) begin
            modelReset();
            return;
        end
        if (m_lu_hold) m_lu_hold = 0;
        else if (m_flush_left > 0) m_flush_left--;
        else if (e_taken) begin
            m_flush_left = FLUSH_CYCLES - 1;
            if (m_flush_cnt < CNT_MAX) m_flush_cnt++;
        end else if (e_stall) begin
            m_lu_hold = 1;
            if (m_stall_cnt < CNT_MAX) m_stall_cnt++;
        end
        dst = dest_of(int'(regdst), int'(rt), int'(rd));
        m_memwb_dst = m_exmem_dst;
        m_memwb_we  = m_exmem_we;
        m_exmem_dst = dst;
        m_exmem_we  = regwrite && (dst != 0) && !m_prev_flush;
        m_exmem_ld  = (mem2reg == 2'b01);
        m_prev_flush = e_idexflush;
    endtask

    task automatic compareVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        compareVal({tag, ".fwdA"}, 32'(fwd_a), 32'(e_fwda));
        compareVal({tag, ".fwdB"}, 32'(fwd_b), 32'(e_fwdb));
        compareVal({tag, ".stall"}, 32'(stall), 32'(e_stall));
        compareVal({tag, ".idexFlush"}, 32'(idex_flush), 32'(e_idexflush));
        compareVal({tag, ".ifidFlush"}, 32'(ifid_flush), 32'(e_ifidflush));
        compareVal({tag, ".taken"}, 32'(br_taken), 32'(e_taken));
        compareVal({tag, ".stallCnt"}, 32'(stall_count), 32'(m_stall_cnt));
        compareVal({tag, ".flushCnt"}, 32'(flush_count), 32'(m_flush_cnt));
    endtask

    // One clock of traffic: drive at the falling edge, check mid-cycle, advance model at the rising edge.
    task automatic applyStimulus(input string tag, input bit rst,
                                 input logic w, input logic [1:0] m2r, input logic [1:0] dsel,
                                 input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                                 input logic bq, input logic bn, input logic z,
                                 input logic [4:0] frs, input logic [4:0] frt);
        @(negedge clock);
        reset = rst;
        regwrite = w; mem2reg = m2r; regdst = dsel;
        rs = s; rt = t; rd = d;
        beq = bq; bne = bn; zero = z;
        ifid_rs = frs; ifid_rt = frt;
        #1;
        if (rst) modelReset();
        computeExpected();
        checkOutput(tag);
        @(posedge clock);
        advanceModel();
    endtask

    task automatic nop(input string tag);
        applyStimulus(tag, 0, 0, 2'b00, 2'b11, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 5'd0);
    endtask

    initial begin
        modelReset();
        $display("[TB] start");

        // Reset state with inputs that would otherwise forward and branch
        applyStimulus("reset0", 1, 1, 2'b01, 2'b01, 5'd3, 5'd3, 5'd3, 1, 0, 1, 5'd3, 5'd3);
        applyStimulus("reset1", 1, 0, 2'b00, 2'b11, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 5'd0);

        // RAW: add $3,$1,$2 then sub $4,$3,$2 (EX/MEM), then with one gap (MEM/WB)
        applyStimulus("raw_add", 0, 1, 2'b00, 2'b01, 5'd1, 5'd2, 5'd3, 0, 0, 0, 5'd3, 5'd2);
        applyStimulus("raw_sub", 0, 1, 2'b00, 2'b01, 5'd3, 5'd2, 5'd4, 0, 0, 0, 5'd0, 5'd0);
        compareVal("raw_exmem_const", 32'(e_fwda), 32'd1);
        applyStimulus("gap_add", 0, 1, 2'b00, 2'b01, 5'd1, 5'd2, 5'd3, 0, 0, 0, 5'd0, 5'd0);
        nop("gap_nop");
        applyStimulus("gap_sub", 0, 1, 2'b00, 2'b01, 5'd3, 5'd2, 5'd4, 0, 0, 0, 5'd0, 5'd0);
        compareVal("raw_memwb_const", 32'(e_fwda), 32'd2);

        // Load-use: lw $5 with add rs=$5 waiting in ID
        applyStimulus("lu_lw", 0, 1, 2'b01, 2'b00, 5'd1, 5'd5, 5'd0, 0, 0, 0, 5'd5, 5'd6);
        compareVal("lu_stall_const", 32'(stall), 32'd1);
        applyStimulus("lu_bubble", 0, 1, 2'b01, 2'b00, 5'd1, 5'd5, 5'd0, 0, 0, 0, 5'd5, 5'd6);
        compareVal("lu_hold_one_cycle", 32'(stall), 32'd0);
        applyStimulus("lu_add", 0, 1, 2'b00, 2'b01, 5'd5, 5'd6, 5'd7, 0, 0, 0, 5'd0, 5'd0);
        compareVal("lu_fwd_memwb", 32'(fwd_a), 32'd2);
        compareVal("lu_stallcnt_one", 32'(stall_count), 32'd1);

        // Taken beq: one BranchTaken cycle, two flush cycles
        applyStimulus("br_beq", 0, 0, 2'b00, 2'b11, 5'd1, 5'd1, 5'd0, 1, 0, 1, 5'd0, 5'd0);
        applyStimulus("br_flush", 0, 1, 2'b00, 2'b01, 5'd1, 5'd1, 5'd9, 1, 0, 1, 5'd9, 5'd9);
        compareVal("br_second_flush", 32'(ifid_flush), 32'd1);
        nop("br_after");
        compareVal("br_flushcnt_one", 32'(flush_count), 32'd1);

        // Taken branch and load-use match together: branch wins
        applyStimulus("both", 0, 1, 2'b01, 2'b00, 5'd1, 5'd8, 5'd0, 1, 0, 1, 5'd8, 5'd0);
        compareVal("both_no_stall", 32'(stall), 32'd0);
        nop("both_f");
        nop("both_n");

        // $0 destination and no-write destination never forward or stall
        applyStimulus("zero_lw", 0, 1, 2'b01, 2'b00, 5'd1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 5'd0);
        applyStimulus("zero_use", 0, 1, 2'b00, 2'b01, 5'd0, 5'd2, 5'd4, 0, 0, 0, 5'd0, 5'd0);
        applyStimulus("none_def", 0, 1, 2'b00, 2'b11, 5'd1, 5'd2, 5'd7, 0, 0, 0, 5'd7, 5'd7);
        applyStimulus("none_use", 0, 1, 2'b00, 2'b01, 5'd7, 5'd7, 5'd4, 0, 0, 0, 5'd0, 5'd0);
        applyStimulus("ra_jal", 0, 1, 2'b00, 2'b10, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 5'd0);
        applyStimulus("ra_use", 0, 1, 2'b00, 2'b01, 5'd31, 5'd1, 5'd4, 0, 0, 1, 5'd0, 5'd0);

        // Drive both counters into saturation
        for (int i = 0; i < CNT_MAX + 3; i++) begin
            applyStimulus("sat_bne", 0, 0, 2'b00, 2'b11, 5'd1, 5'd2, 5'd0, 0, 1, 0, 5'd0, 5'd0);
            nop("sat_bne_f");
            applyStimulus("sat_lw", 0, 1, 2'b01, 2'b00, 5'd1, 5'd6, 5'd0, 0, 0, 0, 5'd0, 5'd6);
            nop("sat_lw_b");
        end
        compareVal("sat_stall_max", 32'(stall_count), 32'(CNT_MAX));
        compareVal("sat_flush_max", 32'(flush_count), 32'(CNT_MAX));

        // Random traffic on a small register set so hazards are frequent
        modelReset();
        applyStimulus("rst_rand", 1, 0, 2'b00, 2'b11, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 5'd0);
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand", 0, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)));
        end

        // Reset while in the branch flush window
        applyStimulus("rb_beq", 0, 0, 2'b00, 2'b11, 5'd1, 5'd1, 5'd0, 1, 0, 1, 5'd0, 5'd0);
        applyStimulus("rb_reset", 1, 1, 2'b01, 2'b00, 5'd1, 5'd3, 5'd0, 1, 0, 1, 5'd3, 5'd3);
        compareVal("rb_outputs_zero", 32'({fwd_a, fwd_b, stall, idex_flush, ifid_flush, br_taken}), 32'd0);
        applyStimulus("rb_beq2", 0, 0, 2'b00, 2'b11, 5'd1, 5'd1, 5'd0, 1, 0, 1, 5'd0, 5'd0);
        compareVal("rb_run_taken", 32'(br_taken), 32'd1);
        compareVal("rb_cnt_cleared", 32'(flush_count), 32'd0);
        nop("rb_f");
        nop("rb_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
